// File: rtl/param_seq_detect_pkg.sv
// seq_detect_pkg: shared constants for the parameterised sequence detector.
//   MODE_MOORE / MODE_MEALY : encodings of the M (output mode) input
//   OVL_ON / OVL_OFF        : encodings of the OVL (match mode) input
//   qw()                    : width of the Q progress output for a pattern length
package seq_detect_pkg;

    localparam logic MODE_MOORE = 1'b0;
    localparam logic MODE_MEALY = 1'b1;
    localparam logic OVL_ON     = 1'b1;
    localparam logic OVL_OFF    = 1'b0;

    function automatic int unsigned qw(input int unsigned seq_len);
        return $clog2(seq_len + 1);
    endfunction

endpackage

// File: rtl/param_seq_detect_if.sv
// param_seq_detect_if: serial bit stream and detector outputs.
//   M, OVL        mode selects (Moore/Mealy, overlap on/off)
//   valid, X      qualified serial data bit
//   Q             current match progress, qw(SEQ_LEN) bits
//   Z             detect pulse
//   match_cnt     number of detections, CNT_W bits
// master = stimulus side, slave = detector side.
interface param_seq_detect_if
    import seq_detect_pkg::*;
#(
    parameter int unsigned SEQ_LEN = 6,
    parameter int unsigned CNT_W   = 8
);
    localparam int unsigned QW = qw(SEQ_LEN);

    logic             M;
    logic             OVL;
    logic             valid;
    logic             X;
    logic [QW-1:0]    Q;
    logic             Z;
    logic [CNT_W-1:0] match_cnt;

    modport master (output M, OVL, valid, X, input Q, Z, match_cnt);
    modport slave  (input M, OVL, valid, X, output Q, Z, match_cnt);

endinterface

// File: rtl/param_seq_detect_match_core.sv
// seq_match_core: bit history, fill count, hit compare and prefix progress.
//   clk, reset  clock and synchronous active-high reset
//   valid, x    qualified serial data bit
//   ovl         1 = overlapping matches (history kept on a hit)
//   hit         accepted bit completes the pattern (combinational)
//   q           longest pattern prefix matching the tail of the stream
module seq_match_core
    import seq_detect_pkg::*;
#(
    parameter int unsigned         SEQ_LEN = 6,
    parameter logic [SEQ_LEN-1:0]  PATTERN = 6'b010110,
    parameter int unsigned         QW      = qw(SEQ_LEN)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          valid,
    input  logic          x,
    input  logic          ovl,
    output logic          hit,
    output logic [QW-1:0] q
);
    localparam int unsigned HW = SEQ_LEN - 1;

    logic [HW-1:0]      history;
    logic [QW-1:0]      fill;
    logic [SEQ_LEN-1:0] window;
    logic               full;
    logic [HW-1:0]      mask_k;
    logic [HW-1:0]      pref_k;

    assign window = {history, x};
    assign full   = (fill == QW'(HW));
    assign hit    = valid & ~reset & full & (window == PATTERN);

    always_ff @(posedge clk) begin
        if (reset) begin
            history <= '0;
            fill    <= '0;
        end else if (valid) begin
            history <= window[HW-1:0];
            if (hit && !ovl)
                fill <= '0;
            else if (!full)
                fill <= fill + QW'(1);
        end
    end

    // Scan prefix lengths upward; the last one that matches within the
    // fill count is the longest. Bits older than fill are never trusted.
    always_comb begin
        q      = '0;
        mask_k = '0;
        pref_k = '0;
        for (int unsigned k = 1; k <= HW; k++) begin
            mask_k = {HW{1'b1}} >> (HW - k);
            pref_k = HW'(PATTERN >> (SEQ_LEN - k));
            if ((QW'(k) <= fill) && (((history ^ pref_k) & mask_k) == '0))
                q = QW'(k);
        end
    end

endmodule

// File: rtl/param_seq_detect.sv
// param_seq_detect: serial pattern detector with Moore/Mealy output and
// overlapping/non-overlapping match modes.
//   clk, reset  clock and synchronous active-high reset
//   bus         param_seq_detect_if.slave (M, OVL, valid, X in; Q, Z, match_cnt out)
// Optional feature: define SEQ_DETECT_CNT_EN to build the saturating
// match counter; otherwise match_cnt is tied to 0.
module param_seq_detect
    import seq_detect_pkg::*;
#(
    parameter int unsigned         SEQ_LEN = 6,
    parameter logic [SEQ_LEN-1:0]  PATTERN = 6'b010110,
    parameter int unsigned         CNT_W   = 8
) (
    input  logic                clk,
    input  logic                reset,
    param_seq_detect_if.slave   bus
);
    localparam int unsigned QW = qw(SEQ_LEN);

    logic          hit;
    logic          hit_q;
    logic [QW-1:0] q;

    seq_match_core #(
        .SEQ_LEN (SEQ_LEN),
        .PATTERN (PATTERN),
        .QW      (QW)
    ) u_core (
        .clk   (clk),
        .reset (reset),
        .valid (bus.valid),
        .x     (bus.X),
        .ovl   (bus.OVL == OVL_ON),
        .hit   (hit),
        .q     (q)
    );

    // Registered hit is kept in both modes so M only re-muxes Z.
    always_ff @(posedge clk) begin
        if (reset)
            hit_q <= 1'b0;
        else
            hit_q <= hit;
    end

    assign bus.Q = q;
    assign bus.Z = (bus.M == MODE_MEALY) ? hit : hit_q;

`ifdef SEQ_DETECT_CNT_EN
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset)
            cnt <= '0;
        else if (hit && (cnt != '1))
            cnt <= cnt + CNT_W'(1);
    end

    assign bus.match_cnt = cnt;
`else
    assign bus.match_cnt = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_param_seq_detect.sv
// tb_param_seq_detect: scoreboard bench for param_seq_detect (SEQ_LEN=6,
// PATTERN=010110). Two instances share stimulus: CNT_W=8 and CNT_W=2.
module tb_param_seq_detect;
    import seq_detect_pkg::*;

    localparam logic [5:0] PAT = 6'b010110;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    param_seq_detect_if #(.SEQ_LEN(6), .CNT_W(8)) bus ();
    param_seq_detect_if #(.SEQ_LEN(6), .CNT_W(2)) bus2 ();

    param_seq_detect #(.SEQ_LEN(6), .PATTERN(PAT), .CNT_W(8)) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );
    param_seq_detect #(.SEQ_LEN(6), .PATTERN(PAT), .CNT_W(2)) dut2 (
        .clk(clk), .reset(reset), .bus(bus2)
    );

    typedef struct {
        int z;
        int q;
        int cnt;
        int cnt2;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: accepted bits since last restart, newest at the back.
    int hist[$];
    int pat[6] = '{0, 1, 0, 1, 1, 0};
    int prev_hit = 0;
    int cnt = 0;
    int cnt2 = 0;

    function automatic int model_q();
        int best = 0;
        for (int k = 1; k <= 5; k++) begin
            bit ok = (k <= hist.size());
            for (int i = 0; i < k && ok; i++)
                if (hist[hist.size() - k + i] != pat[i]) ok = 0;
            if (ok) best = k;
        end
        return best;
    endfunction

    function automatic int model_hit(input int x);
        if (hist.size() < 5) return 0;
        for (int i = 0; i < 5; i++)
            if (hist[hist.size() - 5 + i] != pat[i]) return 0;
        return (x == pat[5]) ? 1 : 0;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    task automatic step(input int r, input int v, input int x, input int m, input int ovl);
        int   hit;
        exp_t e;
        @(posedge clk);
        #2;
        reset      = r[0];
        bus.valid  = v[0];  bus2.valid = v[0];
        bus.X      = x[0];  bus2.X     = x[0];
        bus.M      = m[0];  bus2.M     = m[0];
        bus.OVL    = ovl[0]; bus2.OVL  = ovl[0];

        hit = (r == 0 && v != 0) ? model_hit(x) : 0;
        e.z = (m != 0) ? hit : prev_hit;
        if (r != 0) begin
            hist.delete();
            prev_hit = 0;
            cnt  = 0;
            cnt2 = 0;
        end else begin
            prev_hit = hit;
            if (v != 0) begin
                if (hit != 0 && ovl == 0) begin
                    hist.delete();
                end else begin
                    hist.push_back(x);
                    if (hist.size() > 5) void'(hist.pop_front());
                end
            end
            if (hit != 0) begin
                if (cnt  < 255) cnt++;
                if (cnt2 < 3)   cnt2++;
            end
        end
        e.q = model_q();
`ifdef SEQ_DETECT_CNT_EN
        e.cnt  = cnt;
        e.cnt2 = cnt2;
`else
        e.cnt  = 0;
        e.cnt2 = 0;
`endif
        sb.push_back(e);
    endtask

    task automatic feed(input logic [31:0] bits, input int n, input int m, input int ovl);
        for (int i = n - 1; i >= 0; i--)
            step(0, 1, int'(bits[i]), m, ovl);
    endtask

    // Monitor: Z checked mid-cycle with inputs stable, state checked after the edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("Z", 32'(bus.Z), e.z);
                chk("Z_w2", 32'(bus2.Z), e.z);
                @(posedge clk);
                #1;
                chk("Q", 32'(bus.Q), e.q);
                chk("Q_w2", 32'(bus2.Q), e.q);
                chk("match_cnt", 32'(bus.match_cnt), e.cnt);
                chk("match_cnt_w2", 32'(bus2.match_cnt), e.cnt2);
            end
        end
    end

    initial begin
        reset = 1'b1;
        bus.valid = 1'b0; bus.X = 1'b0; bus.M = MODE_MEALY; bus.OVL = OVL_OFF;
        bus2.valid = 1'b0; bus2.X = 1'b0; bus2.M = MODE_MEALY; bus2.OVL = OVL_OFF;

        step(1, 0, 0, 1, 0);
        step(1, 1, 0, 1, 0);                      // reset wins over valid

        feed(32'b010110, 6, 1, 0);                // Mealy single pattern
        step(1, 0, 0, 0, 0);
        feed(32'b010110, 6, 0, 0);                // Moore single pattern
        step(0, 0, 0, 0, 0);

        step(1, 0, 0, 1, 1);
        feed(32'b01011010110, 11, 1, 1);          // overlapping: two hits
        step(1, 0, 0, 1, 0);
        feed(32'b01011010110, 11, 1, 0);          // non-overlapping: one hit

        step(1, 0, 0, 1, 0);
        feed(32'b010, 3, 1, 0);                   // valid gaps hold progress
        for (int i = 0; i < 3; i++) step(0, 0, i & 1, 1, 0);
        feed(32'b110, 3, 1, 0);

        step(1, 0, 0, 1, 0);
        feed(32'b0101, 4, 1, 0);                  // reset mid-sequence
        step(1, 1, 1, 1, 0);
        feed(32'b10, 2, 1, 0);
        feed(32'b010110, 6, 1, 0);

        step(1, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) feed(32'b010110, 6, 0, 0);   // counter saturation
        for (int i = 0; i < 2; i++) feed(32'b010110, 6, 1, 1);

        for (int i = 0; i < 600; i++) begin
            int r = ($urandom_range(0, 59) == 0) ? 1 : 0;
            int v = ($urandom_range(0, 3) != 0) ? 1 : 0;
            int m = ($urandom_range(0, 15) == 0) ? int'($urandom_range(0, 1)) : int'(bus.M);
            int o = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 1)) : int'(bus.OVL);
            if ($urandom_range(0, 4) == 0 && r == 0)
                feed(32'b010110, 6, m, o);
            else
                step(r, v, int'($urandom_range(0, 1)), m, o);
        end

        step(0, 0, 0, 0, 0);
        repeat (3) @(posedge clk);
        #2;
        chk("scoreboard_drained", 32'(sb.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
